// File: rtl/sys_bus_lsu_if.sv
// Core-side and system-bus-side signal bundle of the load/store unit.
// The master modport is the LSU view; the slave modport is the view of the
// environment (core pipeline plus bus peripherals) that surrounds it.
interface sys_bus_lsu_if;
    // core side
    logic        core_req_i;
    logic        core_we_i;
    logic [2:0]  core_size_i;
    logic [31:0] core_addr_i;
    logic [31:0] core_wd_i;
    logic [31:0] core_rd_o;
    logic        core_stall_o;
    logic        misalign_o;
    logic        timeout_o;
    // system bus side
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_rd_i;
    logic        mem_ready_i;

    modport master (
        input  core_req_i,
        input  core_we_i,
        input  core_size_i,
        input  core_addr_i,
        input  core_wd_i,
        output core_rd_o,
        output core_stall_o,
        output misalign_o,
        output timeout_o,
        output mem_req_o,
        output mem_we_o,
        output mem_be_o,
        output mem_addr_o,
        output mem_wd_o,
        input  mem_rd_i,
        input  mem_ready_i
    );

    modport slave (
        output core_req_i,
        output core_we_i,
        output core_size_i,
        output core_addr_i,
        output core_wd_i,
        input  core_rd_o,
        input  core_stall_o,
        input  misalign_o,
        input  timeout_o,
        input  mem_req_o,
        input  mem_we_o,
        input  mem_be_o,
        input  mem_addr_o,
        input  mem_wd_o,
        output mem_rd_i,
        output mem_ready_i
    );
endinterface

// File: rtl/sys_bus_lsu.sv
// Load/store unit bridging the core pipeline to a single-beat system bus.
// A request is captured in IDLE, issued in BUS until the peripheral answers
// (or the cycle budget runs out), and retired for exactly one cycle in DONE.
// Misaligned or illegal-size requests skip the bus and raise a fault pulse.
module sys_bus_lsu #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    sys_bus_lsu_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT);

    state_t      state_reg, state_next;

    // request captured on acceptance; drives the bus for the whole BUS state
    logic        we_reg;
    logic [2:0]  size_reg;
    logic [31:0] addr_reg;
    logic [31:0] wd_reg;

    // BUS cycle counter (first BUS cycle reads 1) and fault flags for DONE
    logic [7:0]  cnt_reg;
    logic        misalign_reg;
    logic        timeout_reg;

    // already-extended load result; core_rd_o shows it permanently
    logic [31:0] rd_reg;

    logic        req_misaligned;
    logic        timeout_hit;
    logic [3:0]  be_lane;
    logic [31:0] wd_lane;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_ext;

    logic        core_stall;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic        misalign_pulse;
    logic        timeout_pulse;

    // Alignment/legality check on the incoming request; illegal size codes
    // are folded into the misaligned class so they never reach the bus.
    always_comb begin
        req_misaligned = 1'b1;
        case (bus.core_size_i)
            3'b000, 3'b100: req_misaligned = 1'b0;
            3'b001, 3'b101: req_misaligned = bus.core_addr_i[0];
            3'b010:         req_misaligned = |bus.core_addr_i[1:0];
            default:        req_misaligned = 1'b1;
        endcase
    end

    // The limit only fires when the peripheral is silent, so a ready on the
    // last allowed cycle completes normally.
    assign timeout_hit = (cnt_reg == TIMEOUT_LIMIT) && !bus.mem_ready_i;

    // Per-lane byte enables and write data. Only legal sizes reach BUS, so
    // size_reg[1:0] is 00 (byte), 01 (half) or 10 (word) here.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign be_lane[gi] =
                (size_reg[1:0] == 2'b00) ? (addr_reg[1:0] == 2'(gi)) :
                (size_reg[1:0] == 2'b01) ? (addr_reg[1] == 1'(gi / 2)) :
                                           1'b1;
            assign wd_lane[gi*8 +: 8] =
                (size_reg[1:0] == 2'b00) ? wd_reg[7:0] :
                (size_reg[1:0] == 2'b01) ? wd_reg[(gi % 2)*8 +: 8] :
                                           wd_reg[gi*8 +: 8];
        end
    endgenerate

    // Lane selection of the returning read data.
    assign load_byte = bus.mem_rd_i[{addr_reg[1:0], 3'b000} +: 8];
    assign load_half = addr_reg[1] ? bus.mem_rd_i[31:16] : bus.mem_rd_i[15:0];

    // Sign/zero extension according to the captured load size.
    always_comb begin
        load_ext = bus.mem_rd_i;
        case (size_reg)
            3'b000:  load_ext = {{24{load_byte[7]}}, load_byte};
            3'b100:  load_ext = {24'd0, load_byte};
            3'b001:  load_ext = {{16{load_half[15]}}, load_half};
            3'b101:  load_ext = {16'd0, load_half};
            default: load_ext = bus.mem_rd_i;
        endcase
    end

    // State register; reset lands in IDLE immediately so an in-flight bus
    // request is withdrawn without waiting for the peripheral.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and output decode; every output is a pure function of the
    // state and captured registers except the IDLE stall, which mirrors the
    // live request so the core freezes in the same cycle it asks.
    always_comb begin
        state_next     = state_reg;
        core_stall     = 1'b0;
        mem_req        = 1'b0;
        mem_we         = 1'b0;
        mem_be         = 4'b0000;
        mem_addr       = 32'd0;
        mem_wd         = 32'd0;
        misalign_pulse = 1'b0;
        timeout_pulse  = 1'b0;
        case (state_reg)
            IDLE: begin
                core_stall = bus.core_req_i;
                if (bus.core_req_i) begin
                    state_next = req_misaligned ? DONE : BUS;
                end
            end
            BUS: begin
                core_stall = 1'b1;
                mem_req    = 1'b1;
                mem_we     = we_reg;
                mem_be     = be_lane;
                mem_addr   = addr_reg;
                mem_wd     = wd_lane;
                if (bus.mem_ready_i || timeout_hit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                misalign_pulse = misalign_reg;
                timeout_pulse  = timeout_reg;
                state_next     = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request capture, BUS cycle counting, fault flags and load result.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            we_reg       <= 1'b0;
            size_reg     <= 3'b000;
            addr_reg     <= 32'd0;
            wd_reg       <= 32'd0;
            cnt_reg      <= 8'd0;
            misalign_reg <= 1'b0;
            timeout_reg  <= 1'b0;
            rd_reg       <= 32'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.core_req_i) begin
                        we_reg       <= bus.core_we_i;
                        size_reg     <= bus.core_size_i;
                        addr_reg     <= bus.core_addr_i;
                        wd_reg       <= bus.core_wd_i;
                        misalign_reg <= req_misaligned;
                        timeout_reg  <= 1'b0;
                        cnt_reg      <= 8'd1;
                    end
                end
                BUS: begin
                    if (bus.mem_ready_i) begin
                        if (!we_reg) begin
                            rd_reg <= load_ext;
                        end
                    end else if (timeout_hit) begin
                        timeout_reg <= 1'b1;
                        rd_reg      <= 32'd0;
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                end
                DONE: begin
                    misalign_reg <= 1'b0;
                    timeout_reg  <= 1'b0;
                    cnt_reg      <= 8'd0;
                end
                default: begin
                    cnt_reg <= 8'd0;
                end
            endcase
        end
    end

    assign bus.core_stall_o = core_stall;
    assign bus.core_rd_o    = rd_reg;
    assign bus.misalign_o   = misalign_pulse;
    assign bus.timeout_o    = timeout_pulse;
    assign bus.mem_req_o    = mem_req;
    assign bus.mem_we_o     = mem_we;
    assign bus.mem_be_o     = mem_be;
    assign bus.mem_addr_o   = mem_addr;
    assign bus.mem_wd_o     = mem_wd;

endmodule

// File: doc/sys_bus_lsu.md
SYS_BUS_LSU -- requirements
Module: sys_bus_lsu

Interface
REQ-001 SHALL have parameter: TIMEOUT, 255, maximum BUS-state cycles waiting for mem_ready_i (1..255).
REQ-002 SHALL have ports, clock and reset first; one clock, reset asynchronous and active-low:
- clk_i  input  1  system clock; all state changes on its rising edge
- rst_ni  input  1  asynchronous active-low reset
- core_req_i  input  1  core requests a memory/peripheral access
- core_we_i  input  1  1 = store, 0 = load
- core_size_i  input  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- core_addr_i  input  32  byte address
- core_wd_i  input  32  store data, LSB-aligned
- core_rd_o  output  32  extended load data
- core_stall_o  output  1  core holds its request and the pipeline
- misalign_o  output  1  one-cycle fault pulse: misaligned access
- timeout_o  output  1  one-cycle fault pulse: bus timeout
- mem_req_o  output  1  system-bus request to peripherals/memory
- mem_we_o  output  1  system-bus write enable
- mem_be_o  output  4  byte enables
- mem_addr_o  output  32  system-bus address
- mem_wd_o  output  32  system-bus write data
- mem_rd_i  input  32  system-bus read data
- mem_ready_i  input  1  peripheral completed the access this cycle

Function
REQ-003 SHALL implement FSM with states IDLE, BUS, DONE.
REQ-004 IDLE: core_stall_o SHALL equal core_req_i combinationally; mem_req_o SHALL be 0.
REQ-005 IDLE with core_req_i=1 SHALL capture we, size, addr, wd into internal registers on the clock edge.
REQ-006 Access aligned (LW: addr[1:0]=00; LH/LHU: addr[0]=0; byte always) SHALL go IDLE->BUS; misaligned SHALL go IDLE->DONE with misalign flag set and no bus request.
REQ-007 Illegal core_size_i values (011, 110, 111) SHALL be treated as misaligned.
REQ-008 BUS: mem_req_o=1, core_stall_o=1; mem_we_o, mem_addr_o, mem_be_o, mem_wd_o SHALL be driven from captured registers and be stable for the whole state.
REQ-009 mem_addr_o SHALL equal the captured address unmodified (including addr[1:0]).
REQ-010 mem_be_o: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111; identical for loads and stores.
REQ-011 mem_wd_o: byte wd[7:0] replicated x4; half wd[15:0] replicated x2; word wd.
REQ-012 BUS with mem_ready_i=1 SHALL capture mem_rd_i into the load register (loads only) and go BUS->DONE.
REQ-013 Load extension: byte lane selected by addr[1:0], half lane by addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged.
REQ-014 BUS SHALL count cycles from 1; at count TIMEOUT without mem_ready_i SHALL go BUS->DONE with timeout flag set and load register cleared to 0; mem_ready_i on the same cycle as the limit SHALL win (normal completion, no timeout).
REQ-015 DONE: core_stall_o=0, mem_req_o=0; core_rd_o SHALL present the load register; misalign_o/timeout_o SHALL be asserted exactly this one cycle if the corresponding flag is set.
REQ-016 DONE SHALL go to IDLE unconditionally; a core_req_i present in DONE SHALL be ignored and seen again in IDLE next cycle.
REQ-017 core_rd_o SHALL hold its value until the next completed load; stores and faults other than timeout SHALL not alter it.
REQ-018 Latency: aligned access with mem_ready_i in first BUS cycle SHALL stall 2 cycles and release in the 3rd (IDLE, BUS, DONE).
REQ-019 mem_rd_i SHALL be ignored outside BUS.

Reset
REQ-020 rst_ni=0 SHALL immediately (asynchronously) force state IDLE, counter 0, flags 0, load register 0, and all captured registers 0.
REQ-021 During reset mem_req_o, mem_we_o, misalign_o, timeout_o SHALL be 0; core_stall_o SHALL follow REQ-004; core_rd_o SHALL be 0.
REQ-022 Reset asserted in BUS SHALL drop mem_req_o in the same cycle without waiting for mem_ready_i; no fault pulse SHALL be produced.

Verification
REQ-023 LB addr 0x8000_0003, mem_rd_i 0x80FF_1234, ready in first BUS cycle -> stall 2 cycles, mem_be_o 1000, core_rd_o 0xFFFF_FF80 in DONE.
REQ-024 SH addr 0x8000_0002, wd 0x0000_ABCD -> mem_be_o 1100, mem_wd_o 0xABCD_ABCD, mem_we_o 1; LHU same address with mem_rd_i 0xABCD_0000 -> core_rd_o 0x0000_ABCD.
REQ-025 LW addr 0x8000_0001 -> no mem_req_o, DONE next cycle, misalign_o 1 for one cycle, core_rd_o unchanged.
REQ-026 TIMEOUT=4, mem_ready_i held 0 -> mem_req_o high exactly 4 cycles, timeout_o pulse, core_rd_o 0; repeat with mem_ready_i=1 on 4th cycle -> no timeout, data captured.
REQ-027 rst_ni low mid-BUS -> mem_req_o 0 same cycle, state IDLE, no pulse; after release a LW 0x8000_0000 completes normally.
REQ-028 Back-to-back: core_req_i held through DONE -> exactly one bus access per request, next access starts from IDLE the following cycle.
